// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA byte-channel arbiter.
package acia_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        POP     = 2'd2
    } arb_state_t;

    localparam logic CHAN_IKBD = 1'b0;
    localparam logic CHAN_MIDI = 1'b1;

    // Round-robin pick: a lone requester always wins; on a tie the source
    // that was not granted last wins.
    function automatic logic rr_pick(input logic ikbd_req,
                                     input logic midi_req,
                                     input logic last);
        logic pick;
        if (ikbd_req && midi_req)
            pick = ~last;
        else if (midi_req)
            pick = CHAN_MIDI;
        else
            pick = CHAN_IKBD;
        return pick;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with a one-cycle
// rising-edge pulse taken from the last stage. STAGES must be at least 2.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/acia_link_arbiter.sv
// Round-robin arbiter putting IKBD and MIDI bytes onto the single IO
// controller byte channel. Define ACIA_ARB_TIMEOUT_EN to discard unacked bytes.
module acia_link_arbiter
    import acia_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ikbd_avail,
    input  logic [7:0] ikbd_data,
    output logic       ikbd_pop,
    input  logic       midi_avail,
    input  logic [7:0] midi_data,
    output logic       midi_pop,
    output logic       io_avail,
    output logic       io_chan,
    output logic [7:0] io_data,
    input  logic       io_strobe,
    output logic [7:0] drop_count
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("acia_link_arbiter: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       avail_d, chan_d, ikbd_pop_d, midi_pop_d;
    logic [7:0] data_d;
    logic       ack_rise;
    logic       grant_avail;
    logic       pick;
    logic       expired;
    logic       drop_inc;

    sync_edge #(.STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk   (clk),
        .reset (reset),
        .din   (io_strobe),
        .rise  (ack_rise)
    );

    assign grant_avail = (io_chan == CHAN_MIDI) ? midi_avail : ikbd_avail;
    assign pick        = rr_pick(ikbd_avail, midi_avail, last_q);

`ifdef ACIA_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 14) ? $clog2(TIMEOUT_CYCLES) : 14;

    logic [CNT_W-1:0] wait_cnt_q;
    logic [7:0]       drop_q;

    assign expired    = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            drop_q     <= 8'd0;
        end else begin
            if (state_q != PRESENT)
                wait_cnt_q <= '0;
            else
                wait_cnt_q <= wait_cnt_q + 1'b1;
            if (drop_inc && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end
`else
    assign expired    = 1'b0;
    assign drop_count = 8'd0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        avail_d    = 1'b0;
        chan_d     = io_chan;
        data_d     = io_data;
        ikbd_pop_d = 1'b0;
        midi_pop_d = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ikbd_avail || midi_avail) begin
                    chan_d  = pick;
                    data_d  = (pick == CHAN_MIDI) ? midi_data : ikbd_data;
                    last_d  = pick;
                    avail_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                avail_d = 1'b1;
                // Ack beats a simultaneous withdraw; withdraw beats expiry
                // since a reset source has nothing left to pop.
                if (ack_rise) begin
                    avail_d    = 1'b0;
                    ikbd_pop_d = (io_chan == CHAN_IKBD);
                    midi_pop_d = (io_chan == CHAN_MIDI);
                    state_d    = POP;
                end else if (!grant_avail) begin
                    avail_d = 1'b0;
                    state_d = IDLE;
                end else if (expired) begin
                    avail_d    = 1'b0;
                    ikbd_pop_d = (io_chan == CHAN_IKBD);
                    midi_pop_d = (io_chan == CHAN_MIDI);
                    drop_inc   = 1'b1;
                    state_d    = POP;
                end
            end
            POP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= CHAN_MIDI;
            io_avail <= 1'b0;
            io_chan  <= CHAN_IKBD;
            io_data  <= 8'h00;
            ikbd_pop <= 1'b0;
            midi_pop <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            io_avail <= avail_d;
            io_chan  <= chan_d;
            io_data  <= data_d;
            ikbd_pop <= ikbd_pop_d;
            midi_pop <= midi_pop_d;
        end
    end

endmodule

// File: tb/tb_acia_link_arbiter.sv
// Directed bench for acia_link_arbiter: cycle table plus hand-written
// withdraw, idle-strobe, reset and (with ACIA_ARB_TIMEOUT_EN) timeout sequences.
module tb_acia_link_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ikbd_avail, midi_avail, io_strobe;
    logic [7:0] ikbd_data, midi_data;
    logic       ikbd_pop, midi_pop, io_avail, io_chan;
    logic [7:0] io_data, drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acia_link_arbiter #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ikbd_avail (ikbd_avail),
        .ikbd_data  (ikbd_data),
        .ikbd_pop   (ikbd_pop),
        .midi_avail (midi_avail),
        .midi_data  (midi_data),
        .midi_pop   (midi_pop),
        .io_avail   (io_avail),
        .io_chan    (io_chan),
        .io_data    (io_data),
        .io_strobe  (io_strobe),
        .drop_count (drop_count)
    );

    typedef struct {
        logic       ik;
        logic [7:0] ikd;
        logic       mi;
        logic [7:0] mid;
        logic       st;
        logic       e_avail;
        logic       e_chan;
        logic [7:0] e_data;
        logic       e_ipop;
        logic       e_mpop;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ik, input logic [7:0] ikd, input logic mi,
                         input logic [7:0] mid, input logic st);
        @(negedge clk);
        ikbd_avail = ik;
        ikbd_data  = ikd;
        midi_avail = mi;
        midi_data  = mid;
        io_strobe  = st;
    endtask

    task automatic chk_out(input string name, input int row, input logic av, input logic ch,
                           input logic [7:0] d, input logic ip, input logic mp);
        chk({name, ".avail"}, row, {7'd0, io_avail}, {7'd0, av});
        chk({name, ".chan"},  row, {7'd0, io_chan},  {7'd0, ch});
        chk({name, ".data"},  row, io_data, d);
        chk({name, ".ipop"},  row, {7'd0, ikbd_pop}, {7'd0, ip});
        chk({name, ".mpop"},  row, {7'd0, midi_pop}, {7'd0, mp});
    endtask

    initial begin
        // IKBD-only byte, then both sources alternating under continuous availability.
        vecs[0]  = '{1'b1, 8'hF6, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 8'hF6, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hF6, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'hF6, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hF6, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'hF6, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hF6, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'hF6, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'hF6, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};

        reset      = 1'b1;
        ikbd_avail = 1'b0;
        midi_avail = 1'b0;
        ikbd_data  = 8'h00;
        midi_data  = 8'h00;
        io_strobe  = 1'b0;
        repeat (3) step();
        chk_out("reset", 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.drop", 0, drop_count, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ik, vecs[i].ikd, vecs[i].mi, vecs[i].mid, vecs[i].st);
            step();
            chk_out("table", i, vecs[i].e_avail, vecs[i].e_chan, vecs[i].e_data,
                    vecs[i].e_ipop, vecs[i].e_mpop);
            chk("table.pop_excl", i, {7'd0, ikbd_pop & midi_pop}, 8'd0);
            chk("table.drop", i, drop_count, 8'd0);
        end

        // Withdraw: granted source vanishes mid-presentation.
        drive(1'b1, 8'h11, 1'b0, 8'h22, 1'b1);
        step();
        chk_out("wd.grant", 0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        drive(1'b0, 8'h11, 1'b0, 8'h22, 1'b1);
        step();
        chk_out("wd.drop", 1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);

        // Strobe toggling with both sources empty: nothing happens.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 8'h11, 1'b0, 8'h22, ((i / 3) % 2) == 0 ? 1'b0 : 1'b1);
            step();
            chk("idle.avail", i, {7'd0, io_avail}, 8'd0);
            chk("idle.pops", i, {6'd0, ikbd_pop, midi_pop}, 8'd0);
        end

        // Reset one cycle after the strobe rise: no pop, outputs cleared, IKBD first after.
        drive(1'b1, 8'h5A, 1'b0, 8'h33, 1'b0);
        step();
        chk_out("rst.grant", 0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        drive(1'b1, 8'h5A, 1'b0, 8'h33, 1'b0);
        step();
        drive(1'b1, 8'h5A, 1'b0, 8'h33, 1'b1);
        step();
        chk_out("rst.pre", 1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("rst.held", i, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("rst.drop", i, drop_count, 8'd0);
        end
        @(negedge clk);
        reset      = 1'b0;
        io_strobe  = 1'b0;
        midi_avail = 1'b1;
        step();
        chk_out("rst.after", 0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 8'h5A, 1'b0, 8'h33, 1'b0);
        step();
        chk("rst.wd", 0, {7'd0, io_avail}, 8'd0);

`ifdef ACIA_ARB_TIMEOUT_EN
        // No ack: byte dropped after 16 PRESENT cycles.
        drive(1'b1, 8'h77, 1'b0, 8'h33, 1'b0);
        step();
        chk("to.grant", 0, {7'd0, io_avail}, 8'd1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk("to.wait_pop", k, {7'd0, ikbd_pop}, 8'd0);
            chk("to.wait_avail", k, {7'd0, io_avail}, 8'd1);
        end
        step();
        chk("to.pop", 16, {7'd0, ikbd_pop}, 8'd1);
        chk("to.drop1", 16, drop_count, 8'd1);
        for (int n = 0; n < 299; n++) begin
            int waited = 0;
            step();
            while (!ikbd_pop && waited < 40) begin
                step();
                waited++;
            end
            if (!ikbd_pop) begin
                total++;
                bad++;
                $display("FAIL to.repeat drop %0d: no pop within 40 cycles", n);
            end
        end
        chk("to.sat", 0, drop_count, 8'd255);
`else
        chk("nodrop", 0, drop_count, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acia_link_arbiter.md
# acia_link_arbiter

Arbitrates the single byte channel from the keyboard/MIDI ACIA block to the IO controller. Two byte sources, the IKBD output FIFO and the MIDI transmit buffer, are shared fairly onto one presented byte. The IO controller acknowledges each byte with a strobe from the SPI domain. The block sits between the ACIA register/FIFO logic and the IO controller SPI interface, and owns the pop pulses into both source FIFOs.

## Interface
- TIMEOUT_CYCLES, default 16384: cycles a presented byte may wait for acknowledge before it is discarded (only with the timeout feature).
- SYNC_STAGES, default 2: synchronizer depth for io_strobe, minimum 2.
- clk  in  1  system clock (8 MHz domain).
- reset  in  1  reset reset, synchronous, active-high; clock clk.
- ikbd_avail  in  1  IKBD source has a byte; ikbd_data valid.
- ikbd_data  in  8  IKBD head byte.
- ikbd_pop  out  1  one-cycle pulse; consume IKBD head byte.
- midi_avail  in  1  MIDI source has a byte.
- midi_data  in  8  MIDI head byte.
- midi_pop  out  1  one-cycle pulse; consume MIDI head byte.
- io_avail  out  1  byte presented to IO controller.
- io_chan  out  1  0 = IKBD, 1 = MIDI.
- io_data  out  8  presented byte (registered).
- io_strobe  in  1  IO controller acknowledge, asynchronous level; a rising edge means the byte was taken.
- drop_count  out  8  saturating count of timed-out bytes.

## Operation
- States: IDLE, PRESENT, POP.
- IDLE: if any avail, grant a source. io_chan and io_data are latched from the granted source, and the state moves to PRESENT.
- Round robin: register last (reset value 1 = MIDI, so IKBD wins the first tie). When both sources are available, grant the source that is not last. A single available source is always granted. last is updated on grant.
- PRESENT: io_avail = 1 and io_data/io_chan are held stable.
  - On an ack edge, pulse the granted pop for one cycle, drive io_avail = 0, and go to POP.
  - If the granted avail deasserts (source master reset), withdraw: io_avail = 0, no pop, go to IDLE.
  - If an ack edge and the avail drop occur in the same cycle, the ack wins.
- POP: a one-cycle settle state so the source can update avail/data, then go to IDLE. Re-grant is possible on the next cycle.
- Ack edge: the rising edge of the last synchronizer stage vs the previous sample. Edges seen in IDLE or POP are ignored (no pop, no state change).
- At most one pop per ack edge. ikbd_pop and midi_pop are never high together.

## Timing
- Reset values: io_avail 0, io_chan 0, io_data 0x00, ikbd_pop 0, midi_pop 0, drop_count 0, state IDLE.
- Grant latency: avail high in cycle N → io_avail high in cycle N+1.
- Ack latency: io_strobe rise → pop pulse SYNC_STAGES+1 cycles later. io_avail falls in the same cycle as the pop pulse.
- Minimum byte period: 3 cycles plus ack latency.
- Reset asserted mid-transfer: all outputs return to reset values the next cycle, with no pop. A byte that was presented but not acknowledged remains in its source.

## Configuration
- ACIA_ARB_TIMEOUT_EN defined:
  - A 14+ bit counter clears on entry to PRESENT and counts every cycle in PRESENT.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack edge, the byte is discarded: pop pulse, io_avail = 0, go to POP, and drop_count increments, saturating at 255.
  - An ack edge in the expiry cycle counts as a normal ack with no drop.
- Not defined: PRESENT waits indefinitely, there is no counter, and drop_count is tied to 0.

## Structure
- Shared package acia_pkg holds the state enum (IDLE, PRESENT, POP) and the constants CHAN_IKBD = 1'b0 and CHAN_MIDI = 1'b1.
- One sub-module, sync_edge: a SYNC_STAGES flop synchronizer with rising-edge pulse output, reused by the ACIA for the other strobes.
- The arbiter FSM, round-robin pointer, output registers and optional timeout counter are in the top module.

## Test plan
- IKBD-only: ikbd_avail = 1, ikbd_data = 0xF6 → io_avail = 1, io_chan = 0, io_data = 0xF6 one cycle later. io_strobe rise → ikbd_pop single pulse 3 cycles later.
- Both sources continuously available, data 0x11 and 0x22, with 4 acks → io_chan sequence 0,1,0,1 and io_data sequence 0x11,0x22,0x11,0x22. The two pops never overlap.
- Withdraw: ikbd_avail drops during PRESENT → io_avail = 0 next cycle, no pop. A later ack edge has no effect.
- Reset asserted one cycle after the io_strobe rise → no pop, all outputs 0, and ikbd is granted first after release.
- With ACIA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no ack → pop after 16 PRESENT cycles and drop_count = 1. Repeating 300 times leaves drop_count = 255.
- io_strobe toggled while both sources are empty → no pops and io_avail stays 0.
